// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive 3-input truth-table sweeper for the function unit self-test
//
// Walks {B,C,D} through 000..111. For each vector it waits SETTLE cycles and then samples y.
// It builds the 8-bit table and compares it against EXPECTED.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a sweep (sampled only in IDLE)
//   abort        in   cancel a sweep in progress (wins over start)
//   B, C, D      out  registered function-unit inputs, B is the MSB of the vector index
//   y            in   function-unit output
//   busy         out  high while a sweep is walking vectors (WAIT/SAMPLE)
//   done         out  one-cycle pulse on sweep completion
//   truth_table  out  captured table, bit i = y sampled for vector i
//   pass         out  last completed sweep had no mismatches
//   err_count    out  mismatch count of current/last sweep (0..8)
//   first_err    out  lowest mismatching vector index, valid when err_count != 0

module truth_table_sweeper #(
    parameter int         SETTLE   = 2,
    parameter logic [7:0] EXPECTED = 8'hA2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       B,
    output logic       C,
    output logic       D,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_FINISH
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] idx_q;
    logic [3:0] cnt_q;

    // The vector index register drives the function unit directly, so B/C/D are registered.
    assign {B, C, D} = idx_q;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (abort)                    state_d = S_IDLE;
                else if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                busy = 1'b1;
                if (abort)              state_d = S_IDLE;
                else if (idx_q == 3'd7) state_d = S_FINISH;
                else                    state_d = S_WAIT;
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= 3'd0;
            cnt_q       <= 4'd0;
            truth_table <= 8'h00;
            pass        <= 1'b0;
            err_count   <= 4'd0;
            first_err   <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        idx_q       <= 3'd0;
                        cnt_q       <= 4'd0;
                        truth_table <= 8'h00;
                        pass        <= 1'b0;
                        err_count   <= 4'd0;
                        first_err   <= 3'd0;
                    end
                end
                S_WAIT: begin
                    if (abort) pass <= 1'b0;
                    else       cnt_q <= cnt_q + 4'd1;
                end
                S_SAMPLE: begin
                    if (abort) begin
                        // Partial results stay visible; the vector holds where it stopped.
                        pass <= 1'b0;
                    end else begin
                        truth_table[idx_q] <= y;
                        if (y != EXPECTED[idx_q]) begin
                            err_count <= err_count + 4'd1;
                            if (err_count == 4'd0) first_err <= idx_q;
                        end
                        if (idx_q != 3'd7) begin
                            idx_q <= idx_q + 3'd1;
                            cnt_q <= 4'd0;
                        end
                    end
                end
                S_FINISH: begin
                    // err_count already includes the final vector's sample.
                    pass <= (err_count == 4'd0);
                end
                default: ;
            endcase
        end
    end

endmodule
